// File: rtl/piso.sv
// piso: parallel-in, serial-out converter.
// Accepts a packed word of depth_p elements (width_p bits each) over a
// valid/ready handshake and emits the elements, element 0 first, over a
// valid/yumi handshake. A shift register plus a skid register let
// back-to-back words stream with no idle cycle between them.
// Optional build macro PISO_LAST_EN adds last_o, which marks the final
// element of each word.
module piso #(
  parameter int width_p = 8,
  parameter int depth_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [width_p*depth_p-1:0] data_i,
  output logic                       valid_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       yumi_i,
  output logic                       busy_o
`ifdef PISO_LAST_EN
  ,
  output logic                       last_o
`endif
);

  localparam int IDX_W = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(depth_p - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [width_p*depth_p-1:0] shift_q, shift_d;
  logic [width_p*depth_p-1:0] skid_q, skid_d;

  logic accept;
  logic take;
  logic take_last;

  // Handshake decode; ready_o comes only from registered state.
  assign valid_o   = (state_q != EMPTY);
  assign ready_o   = (state_q != TWO);
  assign busy_o    = valid_o;
  assign accept    = valid_i & ready_o;
  assign take      = yumi_i & valid_o;
  assign take_last = take & (idx_q == IDX_LAST);
  assign data_o    = valid_o ? shift_q[idx_q*width_p +: width_p] : '0;

`ifdef PISO_LAST_EN
  assign last_o = valid_o & (idx_q == IDX_LAST);
`endif

  // Next-state: element stepping, word loads and skid promotion.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          shift_d = data_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (take_last) begin
          idx_d = '0;
          if (accept) begin
            // Reload in place so the next word follows without a bubble.
            shift_d = data_i;
          end else begin
            state_d = EMPTY;
          end
        end else begin
          if (take) begin
            idx_d = idx_q + IDX_W'(1);
          end
          if (accept) begin
            skid_d  = data_i;
            state_d = TWO;
          end
        end
      end
      TWO: begin
        if (take_last) begin
          idx_d   = '0;
          shift_d = skid_q;
          state_d = ONE;
        end else if (take) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = EMPTY;
        idx_d   = '0;
      end
    endcase
  end

  // Control registers: state and element counter, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= EMPTY;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Data registers: contents are meaningless while state marks them empty.
  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
    skid_q  <= skid_d;
  end

`ifndef SYNTHESIS
  // Flag a consumer taking an element that is not there.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !valid_o))
        else $warning("piso: yumi_i asserted while valid_o=0 (ignored)");
    end
  end
`endif

endmodule

// File: tb/tb_piso.sv
// tb_piso: directed and randomized bench for piso (width_p=8, depth_p=4).
// The reference model is a queue of elements still owed to the consumer:
// an accepted word appends its elements in order, each yumi_i removes one.
// Expected handshake outputs follow from the queue length alone.
module tb_piso;
  localparam int W = 8;
  localparam int D = 4;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic           valid_i;
  logic           ready_o;
  logic [W*D-1:0] data_i;
  logic           valid_o;
  logic [W-1:0]   data_o;
  logic           yumi_i;
  logic           busy_o;
`ifdef PISO_LAST_EN
  logic           last_o;
`endif

  piso #(.width_p(W), .depth_p(D)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .data_o  (data_o),
    .yumi_i  (yumi_i),
    .busy_o  (busy_o)
`ifdef PISO_LAST_EN
    ,
    .last_o  (last_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int ymode = 0;            // 0: never, 1: always, 2: every third cycle, 3: random
  logic [W-1:0]   mq[$];    // elements owed to the consumer, in order
  logic [W*D-1:0] pend[$];  // words the producer still has to hand over
  int vrun;                 // current run of consecutive valid_o cycles
  int vrun_max;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
  endtask

  // One clock: drive inputs after the falling edge, check, then advance the model.
  task automatic tick(input bit rst, input bit yforce);
    bit exp_ready;
    bit v;
    bit y;
    @(negedge clk_i);
    exp_ready = (mq.size() <= D);
    v = (pend.size() > 0);
    case (ymode)
      0:       y = 1'b0;
      1:       y = 1'b1;
      2:       y = (cyc % 3 == 2);
      default: y = 1'($urandom_range(0, 1));
    endcase
    y = yforce ? 1'b1 : (y && mq.size() > 0);
    reset_i = rst;
    valid_i = v;
    data_i  = v ? pend[0] : '0;
    yumi_i  = y;
    #1;
    chk("valid_o", 32'(valid_o), 32'(mq.size() > 0));
    chk("ready_o", 32'(ready_o), 32'(exp_ready));
    chk("busy_o",  32'(busy_o),  32'(mq.size() > 0));
    chk("data_o",  32'(data_o),  (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
`ifdef PISO_LAST_EN
    chk("last_o",  32'(last_o),  32'(mq.size() > 0 && (mq.size() % D) == 1));
`endif
    if (valid_o === 1'b1) vrun++;
    else vrun = 0;
    if (vrun > vrun_max) vrun_max = vrun;
    @(posedge clk_i);
    cyc++;
    if (rst) begin
      mq.delete();
    end else begin
      if (y && mq.size() > 0) void'(mq.pop_front());
      if (v && exp_ready) begin
        for (int k = 0; k < D; k++) mq.push_back(data_i[k*W +: W]);
        void'(pend.pop_front());
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  initial begin
    reset_i = 1'b1;
    valid_i = 1'b0;
    yumi_i  = 1'b0;
    data_i  = '0;

    // Reset state
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    ticks(2);

    // Single word, consumer always ready
    ymode = 1;
    pend.push_back(32'h44332211);
    ticks(7);

    // Back-pressure: yumi every third cycle
    ymode = 2;
    pend.push_back(32'h44332211);
    ticks(16);

    // Gapless streaming of two words
    ymode = 1;
    vrun_max = 0;
    pend.push_back(32'h04030201);
    pend.push_back(32'h08070605);
    ticks(11);
    chk("stream_valid_run", 32'(vrun_max), 32'd8);

    // Full stall: three words offered, consumer idle
    ymode = 0;
    pend.push_back(32'hA3A2A1A0);
    pend.push_back(32'hB3B2B1B0);
    pend.push_back(32'hC3C2C1C0);
    ticks(5);
    chk("stall_third_held", 32'(pend.size()), 32'd1);
    ymode = 1;
    ticks(14);

    // Reset after two of four elements consumed
    pend.push_back(32'hD3D2D1D0);
    ticks(3);
    tick(1'b1, 1'b0);
    ymode = 0;
    ticks(1);
    ymode = 1;
    pend.push_back(32'hE3E2E1E0);
    ticks(7);

    // Illegal yumi while empty: must be ignored
    ymode = 0;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    ticks(2);

    // Randomized traffic
    ymode = 3;
    for (int i = 0; i < 400; i++) begin
      if (pend.size() < 2 && $urandom_range(0, 2) != 0)
        pend.push_back($urandom());
      if (i == 200) tick(1'b1, 1'b0);
      else tick(1'b0, 1'b0);
    end
    pend.delete();
    ymode = 1;
    ticks(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
